// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin 2:1 mux arbiter with a registered select; MUX_ARB_BURST_EN keeps a grant for up to MAX_BURST beats.
// Latency: 1 cycle from request in IDLE to grant/valid; non-burst gives at most 1 beat per 2 cycles.
// Backpressure: grant, S and F hold while F_READY is low; no preemption by the other requester.
module mux_2x1_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S,
  output logic [WIDTH-1:0] F,
  output logic             F_VALID,
  input  logic             F_READY
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;
  logic   sel, sel_nxt;
  logic   xfer;

  assign GNT0    = (state == G0);
  assign GNT1    = (state == G1);
  assign S       = sel;
  assign F_VALID = (GNT0 & REQ0) | (GNT1 & REQ1);
  assign F       = F_VALID ? (sel ? I1 : I0) : '0;
  assign xfer    = F_VALID & F_READY;

`ifdef MUX_ARB_BURST_EN
  logic [7:0] bcnt, bcnt_nxt;
  logic       burst_more;

  // Another beat fits in this grant only if the one just accepted was not the last allowed.
  assign burst_more = ({1'b0, bcnt} + 9'd1) < 9'(MAX_BURST);
`endif

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    sel_nxt   = sel;
`ifdef MUX_ARB_BURST_EN
    bcnt_nxt  = bcnt;
`endif
    unique case (state)
      IDLE: begin
`ifdef MUX_ARB_BURST_EN
        bcnt_nxt = 8'd0;
`endif
        if (REQ0 && !REQ1) begin
          state_nxt = G0;
          sel_nxt   = 1'b0;
        end else if (REQ1 && !REQ0) begin
          state_nxt = G1;
          sel_nxt   = 1'b1;
        end else if (REQ0 && REQ1) begin
          state_nxt = prio ? G1 : G0;
          sel_nxt   = prio;
        end
      end
      G0, G1: begin
        if (xfer) begin
`ifdef MUX_ARB_BURST_EN
          if (burst_more) begin
            bcnt_nxt = bcnt + 8'd1;
          end else begin
            state_nxt = IDLE;
            prio_nxt  = (state == G0);
          end
`else
          state_nxt = IDLE;
          prio_nxt  = (state == G0);
`endif
        end else if (!F_VALID) begin
          // Requester withdrew before any beat was accepted: release without rotating priority.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      prio  <= 1'b0;
      sel   <= 1'b0;
`ifdef MUX_ARB_BURST_EN
      bcnt  <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      sel   <= sel_nxt;
`ifdef MUX_ARB_BURST_EN
      bcnt  <= bcnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed bench for mux_2x1_rr_arbiter: reset, tie rotation, backpressure, withdrawal, mid-transfer reset, burst.
module tb_mux_2x1_rr_arbiter;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             REQ0, REQ1;
  logic [WIDTH-1:0] I0, I1;
  logic             GNT0, GNT1, S, F_VALID, F_READY;
  logic [WIDTH-1:0] F;

  int n_chk = 0;
  int n_err = 0;

  mux_2x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .I0      (I0),
    .I1      (I1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .S       (S),
    .F       (F),
    .F_VALID (F_VALID),
    .F_READY (F_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic g0, input logic g1, input logic s,
                            input logic fv, input logic [WIDTH-1:0] f);
    chk({tag, ".gnt0"},    32'(GNT0),    32'(g0));
    chk({tag, ".gnt1"},    32'(GNT1),    32'(g1));
    chk({tag, ".s"},       32'(S),       32'(s));
    chk({tag, ".f_valid"}, 32'(F_VALID), 32'(fv));
    chk({tag, ".f"},       32'(F),       32'(f));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
    I0 = 8'hA5; I1 = 8'h5A; F_READY = 1'b0;
    tick();
    tick();
    expect_out("rst", 0, 0, 0, 0, 8'h00);
    RST = 1'b0;
    tick();
    expect_out("rel", 1, 0, 0, 1, 8'hA5);
    I0 = 8'h11; I1 = 8'h22;

`ifdef MUX_ARB_BURST_EN
    F_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      expect_out("burst0", 1, 0, 0, 1, 8'h11);
      tick();
    end
    expect_out("burst_gap0", 0, 0, 0, 0, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_out("burst1", 0, 1, 1, 1, 8'h22);
      tick();
    end
    expect_out("burst_gap1", 0, 0, 1, 0, 8'h00);
    tick();
    expect_out("bshort0", 1, 0, 0, 1, 8'h11);
    tick();
    expect_out("bshort1", 1, 0, 0, 1, 8'h11);
    tick();
    REQ0 = 1'b0;
    #1;
    expect_out("bshort_drop", 1, 0, 0, 0, 8'h00);
    tick();
    expect_out("bshort_idle", 0, 0, 0, 0, 8'h00);
    tick();
    expect_out("bshort_g1", 0, 1, 1, 1, 8'h22);
`else
    // Tie rotation with the consumer always ready.
    F_READY = 1'b1;
    #1;
    expect_out("rr0", 1, 0, 0, 1, 8'h11);
    tick();
    expect_out("rr_idle0", 0, 0, 0, 0, 8'h00);
    tick();
    expect_out("rr1", 0, 1, 1, 1, 8'h22);
    tick();
    expect_out("rr_idle1", 0, 0, 1, 0, 8'h00);
    tick();
    expect_out("rr2", 1, 0, 0, 1, 8'h11);
    tick();

    // Backpressure on requester 1.
    F_READY = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_out("bp_hold", 0, 1, 1, 1, 8'h22);
      tick();
    end
    F_READY = 1'b1;
    #1;
    expect_out("bp_go", 0, 1, 1, 1, 8'h22);
    tick();
    F_READY = 1'b0;
    #1;
    expect_out("bp_idle", 0, 0, 1, 0, 8'h00);
    tick();
    expect_out("bp_prio", 1, 0, 0, 1, 8'h11);

    // Withdrawal in G0 with requester 1 still pending.
    REQ0 = 1'b0;
    #1;
    expect_out("wd_drop", 1, 0, 0, 0, 8'h00);
    tick();
    expect_out("wd_idle", 0, 0, 0, 0, 8'h00);
    tick();
    expect_out("wd_g1", 0, 1, 1, 1, 8'h22);
    REQ1 = 1'b0;
    tick();
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    expect_out("wd_g0", 1, 0, 0, 1, 8'h11);
    // Withdrawal must leave priority at requester 0.
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    expect_out("wd_prio", 1, 0, 0, 1, 8'h11);

    // Reset while requester 1 holds a stalled valid beat.
    F_READY = 1'b1;
    tick();
    F_READY = 1'b0;
    tick();
    expect_out("mr_g1", 0, 1, 1, 1, 8'h22);
    RST = 1'b1;
    tick();
    RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    #1;
    expect_out("mr_idle", 0, 0, 0, 0, 8'h00);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    expect_out("mr_prio", 1, 0, 0, 1, 8'h11);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
